imm_ext_stage: RTL and testbench
================================

Name: imm_ext_stage

Overview:
- Parametrised, registered immediate-generation stage for the ARC MIPS decode path. Successor to the single-mode sign/zero extender.
- Supports five extension modes: sign, zero, LUI, branch offset and jump target. Generalised data/immediate widths.
- Sits between the instruction register and the ID/EX boundary.
- Carries a valid/ready handshake with a 2-entry skid buffer so that decode stalls never drop or duplicate an immediate.

Parameters:
- DATA_W, 32, datapath width of the instruction and the output immediate.
- IMM_W, 16, width of the I-type immediate field, taken from instr[IMM_W-1:0].
- JMP_W, 26, width of the J-type target field, taken from instr[JMP_W-1:0].

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_flush  in  1  discard all buffered entries (branch/exception redirect).
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  stage can accept an entry this cycle.
- i_instr  in  DATA_W  instruction word.
- i_mode  in  3  extension mode (values listed under Behaviour).
- i_pc_plus4  in  DATA_W  PC+4 of the instruction; supplies the jump upper bits.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts the output this cycle.
- o_data_imm  out  DATA_W  extended immediate.
- o_illegal  out  1  entry used a reserved mode; o_data_imm is 0.

Behaviour:
- Elaboration checks: DATA_W >= IMM_W+2 and DATA_W >= JMP_W+2, else $error.
- Modes, with imm = i_instr[IMM_W-1:0]:
  - 0 SIGN: imm sign-extended to DATA_W.
  - 1 ZERO: imm zero-extended.
  - 2 LUI: imm << (DATA_W-IMM_W), low bits 0.
  - 3 BRANCH: sign-extended imm << 2, bits shifted out of the top are discarded.
  - 4 JUMP: {i_pc_plus4[DATA_W-1:JMP_W+2], i_instr[JMP_W-1:0], 2'b00}.
  - 5-7: o_data_imm = 0, o_illegal = 1.
- Extension is combinational on accept. The result is registered into the stage, never recomputed from live inputs.
- Latency: an entry accepted in cycle N appears on o_valid/o_data_imm in cycle N+1.
- Handshake:
  - Transfer in when i_valid && o_ready.
  - Transfer out when o_valid && i_ready.
  - o_data_imm and o_illegal are held stable while o_valid && !i_ready.
  - o_valid never drops without a transfer out, except on flush or reset.
- Storage: main register (drives outputs) plus skid register. o_ready = !skid_valid, a registered value with no combinational path from i_ready.
- State machine:
  - EMPTY: in goes to ONE (main loaded).
  - ONE:
    - in && out: stays ONE, main reloaded.
    - in && !out: goes to FULL, skid loaded.
    - !in && out: goes to EMPTY.
  - FULL:
    - out: goes to ONE, main <= skid (no input accepted, since o_ready = 0).
    - !out: stays FULL.
- Ordering is strictly FIFO. The skid entry is never presented before the main entry.
- Flush:
  - i_flush = 1 forces EMPTY next cycle and clears both valids.
  - An entry offered in the same cycle is dropped, even if o_ready = 1.
  - An output transfer in the flush cycle still counts downstream (flush only affects the next state).
- Reset (asynchronous, active-low): state EMPTY, o_valid = 0, o_ready = 1 after release, o_data_imm = 0, o_illegal = 0, skid data = 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Data registers load only on transfer, to avoid needless toggling.

Decomposition:
- Package arc_pkg:
  - typedef enum logic [2:0] imm_mode_e {IMM_SIGN, IMM_ZERO, IMM_LUI, IMM_BRANCH, IMM_JUMP}.
  - typedef enum for skid state {EMPTY, ONE, FULL}.
- Sub-module imm_ext_core:
  - Purely combinational, parametrised identically.
  - Input: instr, mode, pc_plus4. Output: imm, illegal.
  - Instantiated once on the input side.
- The handshake and skid logic stays in imm_ext_stage.

Test Plan:
- Sign/zero, instr = 0x0000_8004, i_ready = 1:
  - mode 0 gives o_data_imm = 0xFFFF_8004.
  - mode 1 gives 0x0000_8004.
  - Each arrives one cycle after accept.
- LUI and BRANCH:
  - instr = 0x0000_1234, mode 2, gives 0x1234_0000.
  - instr = 0x0000_FFFF, mode 3, gives 0xFFFF_FFFC.
- JUMP:
  - instr = 0x0800_0010, pc_plus4 = 0xA000_0004, mode 4, gives 0xA000_0040.
  - mode 6 gives o_data_imm = 0 with o_illegal = 1.
- Backpressure:
  - Stream A, B, C with i_ready = 0.
  - A held on outputs, B in skid, o_ready = 0, C not accepted until a pop.
  - Raise i_ready: outputs A, B, C in order with no loss or duplication.
- Flush with FULL and i_valid = 1: next cycle o_valid = 0, o_ready = 1, and the offered entry never appears.
- Async reset pulsed between clock edges while FULL:
  - o_valid and o_data_imm go to 0 immediately.
  - o_ready = 1 after release.
  - First post-reset entry has 1-cycle latency.

Source files
------------

// File: rtl/arc_pkg.sv
// -----------------------------------------------------------------------------
// arc_pkg
// Shared types for the ARC MIPS decode path immediate-generation stage.
//   imm_mode_e   : extension mode carried alongside each instruction
//   skid_state_e : occupancy of the two-entry output skid buffer
// -----------------------------------------------------------------------------
package arc_pkg;

  // Codes 5..7 are reserved; the extender flags them as illegal.
  typedef enum logic [2:0] {
    IMM_SIGN   = 3'd0,
    IMM_ZERO   = 3'd1,
    IMM_LUI    = 3'd2,
    IMM_BRANCH = 3'd3,
    IMM_JUMP   = 3'd4
  } imm_mode_e;

  // EMPTY : nothing held
  // ONE   : main register holds the presented entry
  // FULL  : main presented, skid holds the next entry in order
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_ext_stage_if.sv
// -----------------------------------------------------------------------------
// imm_ext_stage_if
// Handshake bundle of the immediate-generation stage.
//   i_flush    : discard every buffered entry (redirect)
//   i_valid    : upstream entry valid          o_ready   : stage can accept
//   i_instr    : instruction word              i_mode    : extension mode
//   i_pc_plus4 : PC+4, supplies jump upper bits
//   o_valid    : output entry valid            i_ready   : downstream accepts
//   o_data_imm : extended immediate            o_illegal : reserved mode used
// master = the environment (decode front end plus ID/EX consumer),
// slave  = the stage itself.
// -----------------------------------------------------------------------------
interface imm_ext_stage_if #(
  parameter int DATA_W = 32
);

  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_instr;
  logic [2:0]        i_mode;
  logic [DATA_W-1:0] i_pc_plus4;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data_imm;
  logic              o_illegal;

  modport master (
    output i_flush, i_valid, i_instr, i_mode, i_pc_plus4, i_ready,
    input  o_ready, o_valid, o_data_imm, o_illegal
  );

  modport slave (
    input  i_flush, i_valid, i_instr, i_mode, i_pc_plus4, i_ready,
    output o_ready, o_valid, o_data_imm, o_illegal
  );

endinterface

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extender.
//   instr    in  DATA_W : instruction word (imm = instr[IMM_W-1:0],
//                         jump target = instr[JMP_W-1:0])
//   mode     in  3      : extension mode (arc_pkg::imm_mode_e, 5..7 reserved)
//   pc_plus4 in  DATA_W : PC+4, upper bits form the jump region
//   imm      out DATA_W : extended immediate (0 for reserved modes)
//   illegal  out 1      : reserved mode used
// -----------------------------------------------------------------------------
module imm_ext_core
  import arc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JMP_W  = 26
) (
  input  logic [DATA_W-1:0] instr,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);

  // Both shifted forms need two spare bits above their source field.
  if (DATA_W < IMM_W + 2) begin : g_chk_imm
    $error("imm_ext_core: DATA_W must be >= IMM_W+2");
  end
  if (DATA_W < JMP_W + 2) begin : g_chk_jmp
    $error("imm_ext_core: DATA_W must be >= JMP_W+2");
  end

  logic        [IMM_W-1:0]  imm_fld;
  logic signed [DATA_W-1:0] sext;
  logic        [DATA_W-1:0] zext;
  logic        [DATA_W-1:0] lui;
  logic signed [DATA_W-1:0] branch;
  logic        [DATA_W-1:0] jump;

  assign imm_fld = instr[IMM_W-1:0];
  assign sext    = {{(DATA_W-IMM_W){imm_fld[IMM_W-1]}}, imm_fld};
  assign zext    = {{(DATA_W-IMM_W){1'b0}}, imm_fld};
  assign lui     = {imm_fld, {(DATA_W-IMM_W){1'b0}}};
  // Word offset: the two bits pushed off the top are simply lost.
  assign branch  = {sext[DATA_W-3:0], 2'b00};
  // Jump stays inside the region selected by the upper bits of PC+4.
  assign jump    = {pc_plus4[DATA_W-1:JMP_W+2], instr[JMP_W-1:0], 2'b00};

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_mode_e'(mode))
      IMM_SIGN:   imm = sext;
      IMM_ZERO:   imm = zext;
      IMM_LUI:    imm = lui;
      IMM_BRANCH: imm = branch;
      IMM_JUMP:   imm = jump;
      default:    illegal = 1'b1;
    endcase
  end

  // Opcode/rs bits above the jump field and the low PC bits are not needed.
  logic unused_bits;
  assign unused_bits = ^{instr[DATA_W-1:JMP_W], pc_plus4[JMP_W+1:0]};

endmodule

// File: rtl/imm_ext_stage.sv
// -----------------------------------------------------------------------------
// imm_ext_stage
// Registered immediate-generation stage between the instruction register and
// the ID/EX boundary. Extends on accept and holds results in a two-entry
// skid buffer (main register drives the outputs, skid register holds the
// next entry) so that decode stalls never drop or duplicate an immediate.
//   clock   in : system clock, rising edge
//   reset_n in : asynchronous active-low reset
//   bus        : imm_ext_stage_if.slave (handshake, instruction, result)
// Latency is one cycle; o_ready depends only on registered state.
// -----------------------------------------------------------------------------
module imm_ext_stage
  import arc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JMP_W  = 26
) (
  input  logic            clock,
  input  logic            reset_n,
  imm_ext_stage_if.slave  bus
);

  logic [DATA_W-1:0] ext_imm_p0;
  logic              ext_ill_p0;

  skid_state_e       state_p1;
  skid_state_e       state_nxt;
  logic [DATA_W-1:0] main_imm_p1;
  logic              main_ill_p1;
  logic [DATA_W-1:0] skid_imm_p1;
  logic              skid_ill_p1;

  logic vld_p1;
  logic rdy_p1;
  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // ---- stage p0: combinational extension of the offered entry ----
  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .JMP_W  (JMP_W)
  ) u_core (
    .instr    (bus.i_instr),
    .mode     (bus.i_mode),
    .pc_plus4 (bus.i_pc_plus4),
    .imm      (ext_imm_p0),
    .illegal  (ext_ill_p0)
  );

  // Both flags are decodes of the state register only.
  assign vld_p1   = (state_p1 != EMPTY);
  assign rdy_p1   = (state_p1 != FULL);
  assign in_fire  = bus.i_valid && rdy_p1;
  assign out_fire = vld_p1 && bus.i_ready;

  always_comb begin
    state_nxt      = state_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (in_fire) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A pop in the flush cycle still happened downstream; only what is
    // held afterwards is discarded, and no data register needs to move.
    if (bus.i_flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // ---- stage p1: main/skid registers ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_p1    <= EMPTY;
      main_imm_p1 <= '0;
      main_ill_p1 <= 1'b0;
      skid_imm_p1 <= '0;
      skid_ill_p1 <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (load_main_in) begin
        main_imm_p1 <= ext_imm_p0;
        main_ill_p1 <= ext_ill_p0;
      end else if (load_main_skid) begin
        main_imm_p1 <= skid_imm_p1;
        main_ill_p1 <= skid_ill_p1;
      end
      if (load_skid) begin
        skid_imm_p1 <= ext_imm_p0;
        skid_ill_p1 <= ext_ill_p0;
      end
    end
  end

  assign bus.o_ready    = rdy_p1;
  assign bus.o_valid    = vld_p1;
  assign bus.o_data_imm = main_imm_p1;
  assign bus.o_illegal  = main_ill_p1;

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  imm_ext_stage_if #(.DATA_W(32)) bus ();

  imm_ext_stage #(.DATA_W(32), .IMM_W(16), .JMP_W(26)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference: {illegal, imm} computed with plain integer arithmetic.
  function automatic logic [32:0] ref_ext(logic [31:0] instr, int mode, logic [31:0] pc);
    longint f, sx, r;
    f  = longint'(instr & 32'h0000_FFFF);
    sx = (f >= 32768) ? f - 65536 : f;
    case (mode)
      0: r = sx;
      1: r = f;
      2: r = f * 65536;
      3: r = sx * 4;
      4: r = longint'(pc & 32'hF000_0000) + longint'(instr & 32'h03FF_FFFF) * 4;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r[31:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [2:0] mode, input logic [31:0] pc);
    bus.i_valid    = 1'b1;
    bus.i_instr    = instr;
    bus.i_mode     = mode;
    bus.i_pc_plus4 = pc;
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_instr    = '0;
    bus.i_mode     = '0;
    bus.i_pc_plus4 = '0;
    bus.i_ready    = 1'b0;
    #2;
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ill=%b d=%h want 0 0 0", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    #10 reset_n = 1'b1;
    tick();
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b want 1 0", bus.o_ready, bus.o_valid);
    end
  endtask

  task automatic test_sign_zero();
    bus.i_ready = 1'b1;
    offer(32'h0000_8004, 3'd0, 32'h0);
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL sign_latency: got v=%b before accept edge, want 0", bus.o_valid);
    end
    tick();
    offer(32'h0000_8004, 3'd1, 32'h0);
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== {2'b10, 32'hFFFF_8004}) begin
      errors++;
      $display("FAIL sign_ext: got v=%b ill=%b d=%h want 1 0 ffff8004", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== {2'b10, 32'h0000_8004}) begin
      errors++;
      $display("FAIL zero_ext: got v=%b ill=%b d=%h want 1 0 00008004", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    drain();
  endtask

  task automatic test_lui_branch();
    bus.i_ready = 1'b1;
    offer(32'h0000_1234, 3'd2, 32'h0);
    tick();
    offer(32'h0000_FFFF, 3'd3, 32'h0);
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== {2'b10, 32'h1234_0000}) begin
      errors++;
      $display("FAIL lui: got v=%b ill=%b d=%h want 1 0 12340000", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== {2'b10, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL branch: got v=%b ill=%b d=%h want 1 0 fffffffc", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    drain();
  endtask

  task automatic test_jump_illegal();
    bus.i_ready = 1'b1;
    offer(32'h0800_0010, 3'd4, 32'hA000_0004);
    tick();
    offer(32'h0800_0010, 3'd6, 32'hA000_0004);
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== {2'b10, 32'hA000_0040}) begin
      errors++;
      $display("FAIL jump: got v=%b ill=%b d=%h want 1 0 a0000040", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL illegal_mode: got v=%b ill=%b d=%h want 1 1 00000000", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    offer(32'h0000_00A1, 3'd1, 32'h0);   // A
    tick();
    offer(32'h0000_00B2, 3'd1, 32'h0);   // B
    tick();
    offer(32'h0000_00C3, 3'd1, 32'h0);   // C
    checks++;
    if ({bus.o_valid, bus.o_ready, bus.o_data_imm} !== {2'b10, 32'h0000_00A1}) begin
      errors++;
      $display("FAIL bp_full: got v=%b rdy=%b d=%h want 1 0 000000a1", bus.o_valid, bus.o_ready, bus.o_data_imm);
    end
    tick();
    checks++;
    if ({bus.o_valid, bus.o_ready, bus.o_data_imm} !== {2'b10, 32'h0000_00A1}) begin
      errors++;
      $display("FAIL bp_hold: got v=%b rdy=%b d=%h want 1 0 000000a1", bus.o_valid, bus.o_ready, bus.o_data_imm);
    end
    bus.i_ready = 1'b1;
    tick();
    checks++;
    if ({bus.o_valid, bus.o_ready, bus.o_data_imm} !== {2'b11, 32'h0000_00B2}) begin
      errors++;
      $display("FAIL bp_second: got v=%b rdy=%b d=%h want 1 1 000000b2", bus.o_valid, bus.o_ready, bus.o_data_imm);
    end
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_data_imm} !== {1'b1, 32'h0000_00C3}) begin
      errors++;
      $display("FAIL bp_third: got v=%b d=%h want 1 000000c3", bus.o_valid, bus.o_data_imm);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got v=%b want 0 (duplicate entry)", bus.o_valid);
    end
    drain();
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b0;
    offer(32'h0000_0011, 3'd1, 32'h0);
    tick();
    offer(32'h0000_0022, 3'd1, 32'h0);
    tick();
    offer(32'h0000_0D0D, 3'd1, 32'h0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got v=%b rdy=%b want 0 1", bus.o_valid, bus.o_ready);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got v=%b d=%h want v=0", bus.o_valid, bus.o_data_imm);
    end
    drain();
  endtask

  task automatic test_async_reset();
    bus.i_ready = 1'b0;
    offer(32'h0000_0055, 3'd1, 32'h0);
    tick();
    offer(32'h0000_0066, 3'd1, 32'h0);
    tick();
    bus.i_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_data_imm} !== 33'h0) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h want 0 00000000", bus.o_valid, bus.o_data_imm);
    end
    #2 reset_n = 1'b1;
    tick();
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got rdy=%b v=%b want 1 0", bus.o_ready, bus.o_valid);
    end
    bus.i_ready = 1'b1;
    offer(32'h0000_7FFF, 3'd0, 32'h0);
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_illegal, bus.o_data_imm} !== {2'b10, 32'h0000_7FFF}) begin
      errors++;
      $display("FAIL post_reset_entry: got v=%b ill=%b d=%h want 1 0 00007fff", bus.o_valid, bus.o_illegal, bus.o_data_imm);
    end
    drain();
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic        v, rdy, fl, exp_v, exp_r;
    logic [31:0] instr, pc;
    int          mode;
    for (int i = 0; i < 800; i++) begin
      v     = ($urandom_range(0, 99) < 65);
      rdy   = ($urandom_range(0, 99) < 55);
      fl    = ($urandom_range(0, 99) < 4);
      instr = $urandom;
      pc    = $urandom;
      mode  = $urandom_range(0, 7);
      bus.i_valid    = v;
      bus.i_instr    = instr;
      bus.i_mode     = 3'(mode);
      bus.i_pc_plus4 = pc;
      bus.i_ready    = rdy;
      bus.i_flush    = fl;
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2);
      checks++;
      if (bus.o_valid !== exp_v || bus.o_ready !== exp_r ||
          (exp_v && {bus.o_illegal, bus.o_data_imm} !== q[0])) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b rdy=%b ill=%b d=%h want v=%b rdy=%b ill/d=%h",
                 i, bus.o_valid, bus.o_ready, bus.o_illegal, bus.o_data_imm,
                 exp_v, exp_r, exp_v ? q[0] : 33'h0);
      end
      tick();
      if (exp_v && rdy) void'(q.pop_front());
      if (v && exp_r) q.push_back(ref_ext(instr, mode, pc));
      if (fl) q.delete();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_sign_zero();
    test_lui_branch();
    test_jump_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
